// File: rtl/ram_scan_sequencer.sv
// RAM initialiser/scanner: fills a synchronous RAM with SEED+i after reset, then
// reads one word per divider tick and presents it on a registered output.
module ram_scan_sequencer #(
  parameter int         ADDR_W = 4,
  parameter int         DATA_W = 8,
  parameter logic [7:0] SEED   = 8'h01
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tick,
  input  logic              Pause,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] Dout,
  output logic              DoutValid,
  output logic [ADDR_W-1:0] Addr,
  output logic              InitDone,
  output logic [1:0]        fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);

  typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_READ, ST_OUT} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] init_cnt;
  logic              pending;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;

  logic              mem_we;
  logic              rd_en;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              tick_ok;
  logic              init_last;

  // Tick is a one-cycle pulse with no back-pressure: it is honoured only in
  // ST_WAIT (or deferred once via pending when it collides with a host write);
  // DoutValid is a one-cycle pulse with no ready, one per scanned word.
  assign tick_ok   = Tick && !Pause;
  assign init_last = (init_cnt == ADDR_W'(DEPTH - 1));
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = WrAddr;
    mem_wdata = WrData;
    rd_en     = 1'b0;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_cnt;
        mem_wdata = SEED_W + DATA_W'(init_cnt);
        if (init_last) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mem_we = WrReq;
        // Single port: the read is issued only in a cycle free of host writes.
        if (!WrReq && (tick_ok || pending)) begin
          rd_en     = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        mem_we    = WrReq;
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        mem_we    = WrReq;
        state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      pending   <= 1'b0;
      Dout      <= '0;
      DoutValid <= 1'b0;
      Addr      <= '0;
      InitDone  <= 1'b0;
    end else begin
      state     <= state_nxt;
      DoutValid <= (state == ST_OUT);
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
        if (init_last) InitDone <= 1'b1;
      end
      if (state == ST_WAIT) begin
        if (rd_en) pending <= 1'b0;
        else if (WrReq && tick_ok) pending <= 1'b1;
      end
      if (state == ST_OUT) begin
        Dout <= rdata;
        Addr <= Addr + ADDR_W'(1);
      end
    end
  end

  // rdata is captured at read issue and held through READ/OUT, so host writes
  // in those states cannot disturb the word in flight.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      else if (rd_en) rdata <= mem[Addr];
    end
  end

endmodule

// File: tb/tb_ram_scan_sequencer.sv
// Directed bench for ram_scan_sequencer: reference RAM model plus an expected
// queue of scanned words popped whenever DoutValid pulses.
module tb_ram_scan_sequencer;

  logic       Clk;
  logic       Rst;
  logic       Tick;
  logic       Pause;
  logic       WrReq;
  logic [3:0] WrAddr;
  logic [7:0] WrData;
  logic [7:0] Dout;
  logic       DoutValid;
  logic [3:0] Addr;
  logic       InitDone;
  logic [1:0] fsm_state;

  logic [7:0] exp_q[$];
  logic [7:0] model_mem [16];
  logic [3:0] m_addr;
  int         n_checks;
  int         n_fails;
  int         dv_count;

  ram_scan_sequencer #(.ADDR_W(4), .DATA_W(8), .SEED(8'h01)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Tick      (Tick),
    .Pause     (Pause),
    .WrReq     (WrReq),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .Dout      (Dout),
    .DoutValid (DoutValid),
    .Addr      (Addr),
    .InitDone  (InitDone),
    .fsm_state (fsm_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 2 time units after the rising edge.
  task automatic step();
    logic [7:0] e;
    @(posedge Clk);
    #2;
    if (DoutValid) begin
      dv_count++;
      if (exp_q.size() == 0) check("unexpected_dv", 32'(DoutValid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("dout", 32'(Dout), 32'(e));
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'(8'h01 + i);
    m_addr = 4'd0;
  endtask

  // Tick in WAIT at edge T; DoutValid expected after edge T+2 only.
  task automatic scan_tick();
    Tick = 1'b1;
    exp_q.push_back(model_mem[m_addr]);
    step();
    Tick = 1'b0;
    step();
    check("dv_t1", 32'(DoutValid), 32'd0);
    step();
    check("dv_t2", 32'(DoutValid), 32'd1);
    m_addr = m_addr + 4'd1;
    check("addr", 32'(Addr), 32'(m_addr));
    repeat (5) step();
  endtask

  initial begin
    int dv_before;
    n_checks = 0;
    n_fails  = 0;
    dv_count = 0;
    Rst = 1'b1; Tick = 1'b0; Pause = 1'b0; WrReq = 1'b0; WrAddr = '0; WrData = '0;
    model_reset();

    // Reset state
    repeat (2) step();
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_dv", 32'(DoutValid), 32'd0);
    check("rst_addr", 32'(Addr), 32'd0);
    check("rst_initdone", 32'(InitDone), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);

    // Reset fill: InitDone rises exactly 16 cycles after release; Tick/WrReq ignored
    Rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      Tick  = (k == 5);
      WrReq = (k == 7);
      WrAddr = 4'd2;
      WrData = 8'hEE;
      step();
      check("init_done", 32'(InitDone), (k == 16) ? 32'd1 : 32'd0);
      check("init_addr", 32'(Addr), 32'd0);
      check("init_dout", 32'(Dout), 32'd0);
    end
    Tick = 1'b0; WrReq = 1'b0;
    repeat (3) step();

    // Scan order and wrap: 17 ticks, 8 cycles apart
    for (int n = 0; n < 17; n++) scan_tick();
    check("scan_dv_count", 32'(dv_count), 32'd17);
    check("scan_wrap_addr", 32'(Addr), 32'd1);

    // Tick with Pause=1 is ignored
    dv_before = dv_count;
    Pause = 1'b1; Tick = 1'b1;
    step();
    Pause = 1'b0; Tick = 1'b0;
    repeat (5) step();
    check("pause_dv", 32'(dv_count - dv_before), 32'd0);
    check("pause_addr", 32'(Addr), 32'(m_addr));

    // Tick in the cycle after an accepted tick is dropped
    dv_before = dv_count;
    Tick = 1'b1;
    exp_q.push_back(model_mem[m_addr]);
    step();
    step();
    Tick = 1'b0;
    repeat (8) step();
    m_addr = m_addr + 4'd1;
    check("drop_dv", 32'(dv_count - dv_before), 32'd1);
    check("drop_addr", 32'(Addr), 32'(m_addr));

    // Host write then scan through it
    WrReq = 1'b1; WrAddr = 4'd3; WrData = 8'hA5;
    step();
    WrReq = 1'b0;
    model_mem[3] = 8'hA5;
    repeat (2) step();
    while (m_addr != 4'd5) scan_tick();

    // Write/tick collision: write lands first, read deferred to T+3
    WrReq = 1'b1; WrAddr = m_addr; WrData = 8'h3C; Tick = 1'b1;
    model_mem[m_addr] = 8'h3C;
    exp_q.push_back(model_mem[m_addr]);
    step();
    WrReq = 1'b0; Tick = 1'b0;
    step();
    check("coll_dv_t1", 32'(DoutValid), 32'd0);
    step();
    check("coll_dv_t2", 32'(DoutValid), 32'd0);
    step();
    check("coll_dv_t3", 32'(DoutValid), 32'd1);
    m_addr = m_addr + 4'd1;
    check("coll_addr", 32'(Addr), 32'(m_addr));
    repeat (4) step();

    // Write to the word in flight during READ does not alter the captured word
    Tick = 1'b1;
    exp_q.push_back(model_mem[m_addr]);
    step();
    Tick = 1'b0;
    WrReq = 1'b1; WrAddr = m_addr; WrData = 8'h77;
    check("inflight_state", 32'(fsm_state), 32'd2);
    step();
    WrReq = 1'b0;
    model_mem[m_addr] = 8'h77;
    step();
    check("inflight_dv", 32'(DoutValid), 32'd1);
    m_addr = m_addr + 4'd1;
    repeat (5) step();

    // Reset mid-scan (in READ), then full re-init restores the pattern
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    Rst = 1'b1;
    step();
    check("mrst_dv", 32'(DoutValid), 32'd0);
    check("mrst_addr", 32'(Addr), 32'd0);
    check("mrst_initdone", 32'(InitDone), 32'd0);
    check("mrst_dout", 32'(Dout), 32'd0);
    Rst = 1'b0;
    model_reset();
    repeat (15) step();
    check("reinit_not_done", 32'(InitDone), 32'd0);
    step();
    check("reinit_done", 32'(InitDone), 32'd1);
    repeat (2) step();
    for (int n = 0; n < 4; n++) scan_tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
